uart_rx_core: RTL and testbench

//  Parametrised UART receiver: oversampled start detect, majority-vote bit sampling,

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_tick_gen.sv | 31 +++
 rtl/uart_rx_core.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_core.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg: parity modes, receiver FSM encoding and bit helpers. Rev 1.0
// ============================================================================
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  // Expected parity bit; zero-extended data does not change the XOR.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_tick_gen.sv
`default_nettype none
// ============================================================================
// uart_rx_tick_gen: free-running CLK_DIV divider producing a 1-cycle tick. Rev 1.0
// ============================================================================
module uart_rx_tick_gen #(
  parameter int CLK_DIV = 27
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_q == C_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// uart_rx_core: oversampled UART receiver with one-word valid/ready buffer. Rev 1.0
// ============================================================================
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 27,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX_Pin_In,
  input  logic                 RX_En_Sig,
  output logic [DATA_BITS-1:0] RX_Data,
  output logic                 RX_Valid,
  input  logic                 RX_Ready,
  output logic                 Parity_Err,
  output logic                 Frame_Err,
  output logic                 Overrun_Err,
  output logic                 Busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [SW-1:0] C_SAMP_LO  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] C_SAMP_MID = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] C_SAMP_HI  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] C_SAMP_END = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] C_DATA_CNT = BW'(DATA_BITS);
  localparam logic [BW-1:0] C_STOP_LST = BW'(STOP_BITS - 1);

  logic                 w_tick, w_fall, w_maj, w_decide, w_bit_end, w_commit, w_frm_final;
  logic                 sync1_q, sync2_q, prev_q;
  rx_state_e            state_q, state_d;
  logic [SW-1:0]        samp_q, samp_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [1:0]           vote_q, vote_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d, frm_q, frm_d;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, pe_q, fe_q, ovr_q;

  uart_rx_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk_i  (CLK),
    .rst_i  (RST),
    .tick_o (w_tick)
  );

  assign w_fall    = prev_q & ~sync2_q;
  assign w_maj     = maj3(vote_q[0], vote_q[1], sync2_q);
  assign w_decide  = w_tick && (samp_q == C_SAMP_HI);
  assign w_bit_end = w_tick && (samp_q == C_SAMP_END);

  always_comb begin
    state_d     = state_q;
    samp_d      = samp_q;
    bit_d       = bit_q;
    vote_d      = vote_q;
    shift_d     = shift_q;
    par_d       = par_q;
    frm_d       = frm_q;
    w_commit    = 1'b0;
    w_frm_final = frm_q;
    if (w_tick) begin
      samp_d = (samp_q == C_SAMP_END) ? '0 : samp_q + 1'b1;
      if (samp_q == C_SAMP_LO)  vote_d[0] = sync2_q;
      if (samp_q == C_SAMP_MID) vote_d[1] = sync2_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (w_fall && RX_En_Sig) begin
          state_d = ST_START;
          samp_d  = '0;
          bit_d   = '0;
          par_d   = 1'b0;
          frm_d   = 1'b0;
        end
      end
      ST_START: begin
        if (w_decide && w_maj) state_d = ST_IDLE;
        else if (w_bit_end)    state_d = ST_DATA;
      end
      ST_DATA: begin
        if (w_decide) begin
          shift_d = {w_maj, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
        end
        if (w_bit_end && (bit_q == C_DATA_CNT)) begin
          bit_d   = '0;
          state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (w_decide)  par_d   = (w_maj != parity_bit(9'(shift_q), PARITY));
        if (w_bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (w_decide) begin
          w_frm_final = frm_q | ~w_maj;
          frm_d       = w_frm_final;
          if (bit_q == C_STOP_LST) begin
            w_commit = 1'b1;
            // A line still low after the last stop bit is a break, not a new start.
            state_d  = sync2_q ? ST_IDLE : ST_BREAK;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (sync2_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= ST_IDLE;
      samp_q  <= '0;
      bit_q   <= '0;
      vote_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      frm_q   <= 1'b0;
    end else begin
      sync1_q <= RX_Pin_In;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      vote_q  <= vote_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      frm_q   <= frm_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (valid_q && RX_Ready) begin
        valid_q <= 1'b0;
        pe_q    <= 1'b0;
        fe_q    <= 1'b0;
      end
      if (w_commit) begin
        if (!valid_q || RX_Ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
          pe_q    <= par_q;
          fe_q    <= w_frm_final;
        end else begin
          ovr_q <= 1'b1;
        end
      end
    end
  end

  assign RX_Data     = data_q;
  assign RX_Valid    = valid_q;
  assign Parity_Err  = pe_q;
  assign Frame_Err   = fe_q;
  assign Overrun_Err = ovr_q;
  assign Busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_core: directed frames into 8N1, 7E1 and 8N2 receiver instances. Rev 1.0
// ============================================================================
module tb_uart_rx_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rx[3];
  logic       en[3];
  logic       ready[3];
  logic       valid[3], pe[3], fe[3], ovr[3], busy[3];
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic [7:0] data_c;
  logic [8:0] rdata[3];
  int         bitc[3] = '{432, 64, 64};

  assign rdata[0] = {1'b0, data_a};
  assign rdata[1] = {2'b0, data_b};
  assign rdata[2] = {1'b0, data_c};

  uart_rx_core #(.CLK_DIV(27), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .CLK(clk), .RST(rst), .RX_Pin_In(rx[0]), .RX_En_Sig(en[0]), .RX_Data(data_a),
    .RX_Valid(valid[0]), .RX_Ready(ready[0]), .Parity_Err(pe[0]), .Frame_Err(fe[0]),
    .Overrun_Err(ovr[0]), .Busy(busy[0]));

  uart_rx_core #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_b (
    .CLK(clk), .RST(rst), .RX_Pin_In(rx[1]), .RX_En_Sig(en[1]), .RX_Data(data_b),
    .RX_Valid(valid[1]), .RX_Ready(ready[1]), .Parity_Err(pe[1]), .Frame_Err(fe[1]),
    .Overrun_Err(ovr[1]), .Busy(busy[1]));

  uart_rx_core #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut_c (
    .CLK(clk), .RST(rst), .RX_Pin_In(rx[2]), .RX_En_Sig(en[2]), .RX_Data(data_c),
    .RX_Valid(valid[2]), .RX_Ready(ready[2]), .Parity_Err(pe[2]), .Frame_Err(fe[2]),
    .Overrun_Err(ovr[2]), .Busy(busy[2]));

  int         vcnt[3], ocnt[3], bcnt[3];
  logic [8:0] cap_data[3];
  logic       cap_pe[3], cap_fe[3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (valid[i]) begin
        vcnt[i]     <= vcnt[i] + 1;
        cap_data[i] <= rdata[i];
        cap_pe[i]   <= pe[i];
        cap_fe[i]   <= fe[i];
      end
      if (ovr[i])  ocnt[i] <= ocnt[i] + 1;
      if (busy[i]) bcnt[i] <= bcnt[i] + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_raw(input int d, input logic [15:0] seq, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      #1 rx[d] = seq[i];
      repeat (bitc[d]) @(posedge clk);
    end
  endtask

  task automatic idle_bits(input int d, input int n);
    #1 rx[d] = 1'b1;
    repeat (n * bitc[d]) @(posedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) rx[i] = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int v0, o0, b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx[i] = 1'b1; en[i] = 1'b1; ready[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valid", 32'(valid[0]), 32'd0);
    check("rst_data",  32'(data_a),   32'd0);
    check("rst_busy",  32'(busy[0]),  32'd0);
    check("rst_pe",    32'(pe[0]),    32'd0);
    check("rst_fe",    32'(fe[0]),    32'd0);
    check("rst_ovr",   32'(ovr[0]),   32'd0);

    // 8N1 0xA5, consumer always ready
    @(posedge clk); v0 = vcnt[0];
    send_raw(0, 16'({1'b1, 8'hA5, 1'b0}), 0, 9);
    idle_bits(0, 1);
    check("a5_data",   32'(cap_data[0]), 32'h0A5);
    check("a5_vcyc",   32'(vcnt[0] - v0), 32'd1);
    check("a5_pe",     32'(cap_pe[0]), 32'd0);
    check("a5_fe",     32'(cap_fe[0]), 32'd0);
    check("a5_busy",   32'(busy[0]), 32'd0);

    // 7E1: 0x35 has four ones, even parity bit is 0
    send_raw(1, 16'({1'b1, 1'b1, 7'h35, 1'b0}), 0, 9);
    idle_bits(1, 1);
    check("7e1_bad_data", 32'(cap_data[1]), 32'h35);
    check("7e1_bad_pe",   32'(cap_pe[1]),   32'd1);
    send_raw(1, 16'({1'b1, 1'b0, 7'h35, 1'b0}), 0, 9);
    idle_bits(1, 1);
    check("7e1_ok_pe",    32'(cap_pe[1]),   32'd0);
    send_raw(1, 16'({1'b1, 1'b1, 7'h07, 1'b0}), 0, 9);
    idle_bits(1, 1);
    check("7e1_07_data",  32'(cap_data[1]), 32'h07);
    check("7e1_07_pe",    32'(cap_pe[1]),   32'd0);
    send_raw(1, 16'({1'b1, 1'b0, 7'h07, 1'b0}), 0, 9);
    idle_bits(1, 1);
    check("7e1_07bad_pe", 32'(cap_pe[1]),   32'd1);

    // Stop bit low, then break for 3 bit times, then a clean frame
    @(posedge clk); v0 = vcnt[0];
    send_raw(0, 16'({1'b0, 8'h81, 1'b0}), 0, 9);
    send_raw(0, 16'h0000, 0, 2);
    @(negedge clk);
    check("brk_busy",  32'(busy[0]), 32'd1);
    idle_bits(0, 1);
    check("brk_fe",    32'(cap_fe[0]),   32'd1);
    check("brk_data",  32'(cap_data[0]), 32'h081);
    check("brk_idle",  32'(busy[0]), 32'd0);
    send_raw(0, 16'({1'b1, 8'h3C, 1'b0}), 0, 9);
    idle_bits(0, 1);
    check("post_brk_data", 32'(cap_data[0]), 32'h03C);
    check("post_brk_fe",   32'(cap_fe[0]),   32'd0);
    check("brk_frames",    32'(vcnt[0] - v0), 32'd2);

    // Overrun: buffer holds 0x11 while 0x22 arrives
    #1 ready[0] = 1'b0;
    @(posedge clk); o0 = ocnt[0];
    send_raw(0, 16'({1'b1, 8'h11, 1'b0}), 0, 9);
    idle_bits(0, 1);
    send_raw(0, 16'({1'b1, 8'h22, 1'b0}), 0, 9);
    idle_bits(0, 1);
    @(negedge clk);
    check("ovr_data",   32'(data_a), 32'h11);
    check("ovr_pulses", 32'(ocnt[0] - o0), 32'd1);
    @(posedge clk);
    #1 ready[0] = 1'b1;
    @(negedge clk);
    check("hs_valid_hold", 32'(valid[0]), 32'd1);
    @(negedge clk);
    check("hs_valid_clr",  32'(valid[0]), 32'd0);

    // Glitch of 3 ticks on an idle line
    @(posedge clk); v0 = vcnt[0]; b0 = bcnt[0];
    #1 rx[0] = 1'b0;
    repeat (81) @(posedge clk);
    idle_bits(0, 2);
    check("glitch_novalid", 32'(vcnt[0] - v0), 32'd0);
    check("glitch_idle",    32'(busy[0]), 32'd0);
    check("glitch_busy_seen",   32'((bcnt[0] - b0) > 0),   32'd1);
    check("glitch_busy_le_bit", 32'((bcnt[0] - b0) <= 432), 32'd1);

    // Reset mid-DATA with a word sitting in the buffer
    #1 ready[0] = 1'b0;
    send_raw(0, 16'({1'b1, 8'h77, 1'b0}), 0, 9);
    idle_bits(0, 1);
    @(negedge clk);
    check("pre_rst_valid", 32'(valid[0]), 32'd1);
    send_raw(0, 16'({1'b1, 8'h5A, 1'b0}), 0, 4);
    pulse_reset();
    @(negedge clk);
    check("mrst_valid", 32'(valid[0]), 32'd0);
    check("mrst_data",  32'(data_a),   32'd0);
    check("mrst_busy",  32'(busy[0]),  32'd0);
    #1 ready[0] = 1'b1;
    @(posedge clk); v0 = vcnt[0];
    idle_bits(0, 2);
    check("mrst_novalid", 32'(vcnt[0] - v0), 32'd0);
    send_raw(0, 16'({1'b1, 8'h5A, 1'b0}), 0, 9);
    idle_bits(0, 1);
    check("mrst_5a_data", 32'(cap_data[0]), 32'h05A);
    check("mrst_5a_cnt",  32'(vcnt[0] - v0), 32'd1);

    // 8N2: enable dropped mid-frame still completes the frame
    @(posedge clk); v0 = vcnt[2];
    send_raw(2, 16'({2'b11, 8'h5A, 1'b0}), 0, 3);
    en[2] = 1'b0;
    send_raw(2, 16'({2'b11, 8'h5A, 1'b0}), 4, 10);
    idle_bits(2, 1);
    check("en_drop_data", 32'(cap_data[2]), 32'h05A);
    check("en_drop_cnt",  32'(vcnt[2] - v0), 32'd1);
    @(posedge clk); v0 = vcnt[2]; b0 = bcnt[2];
    send_raw(2, 16'({2'b11, 8'hC3, 1'b0}), 0, 10);
    idle_bits(2, 1);
    check("en_off_novalid", 32'(vcnt[2] - v0), 32'd0);
    check("en_off_nobusy",  32'(bcnt[2] - b0), 32'd0);
    en[2] = 1'b1;

    // 8N2: reset mid-DATA, then a clean frame
    send_raw(2, 16'({2'b11, 8'h5A, 1'b0}), 0, 5);
    pulse_reset();
    @(negedge clk);
    check("c_mrst_busy",  32'(busy[2]),  32'd0);
    check("c_mrst_valid", 32'(valid[2]), 32'd0);
    idle_bits(2, 2);
    @(posedge clk); v0 = vcnt[2];
    send_raw(2, 16'({2'b11, 8'h5A, 1'b0}), 0, 10);
    idle_bits(2, 1);
    check("c_5a_data", 32'(cap_data[2]), 32'h05A);
    check("c_5a_fe",   32'(cap_fe[2]),   32'd0);
    check("c_5a_cnt",  32'(vcnt[2] - v0), 32'd1);

    // 8N2: second stop bit low flags a framing error
    send_raw(2, 16'({2'b01, 8'hE7, 1'b0}), 0, 10);
    idle_bits(2, 2);
    check("c_stop2_fe",   32'(cap_fe[2]),   32'd1);
    check("c_stop2_data", 32'(cap_data[2]), 32'h0E7);
    check("c_stop2_idle", 32'(busy[2]),     32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
